// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder: FSM state
// encoding, the fault NOP and the ROM image.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } imem_state_t;

  localparam logic [31:0] NOP_INSTR = 32'hD503201F;

  localparam int ROM_INIT_WORDS = 64;

  // Word i holds 32'hE3A0_0000 + i, so every entry is distinct and easy to predict.
  localparam logic [31:0] ROM_INIT [ROM_INIT_WORDS] = '{
    32'hE3A00000, 32'hE3A00001, 32'hE3A00002, 32'hE3A00003, 32'hE3A00004, 32'hE3A00005, 32'hE3A00006, 32'hE3A00007,
    32'hE3A00008, 32'hE3A00009, 32'hE3A0000A, 32'hE3A0000B, 32'hE3A0000C, 32'hE3A0000D, 32'hE3A0000E, 32'hE3A0000F,
    32'hE3A00010, 32'hE3A00011, 32'hE3A00012, 32'hE3A00013, 32'hE3A00014, 32'hE3A00015, 32'hE3A00016, 32'hE3A00017,
    32'hE3A00018, 32'hE3A00019, 32'hE3A0001A, 32'hE3A0001B, 32'hE3A0001C, 32'hE3A0001D, 32'hE3A0001E, 32'hE3A0001F,
    32'hE3A00020, 32'hE3A00021, 32'hE3A00022, 32'hE3A00023, 32'hE3A00024, 32'hE3A00025, 32'hE3A00026, 32'hE3A00027,
    32'hE3A00028, 32'hE3A00029, 32'hE3A0002A, 32'hE3A0002B, 32'hE3A0002C, 32'hE3A0002D, 32'hE3A0002E, 32'hE3A0002F,
    32'hE3A00030, 32'hE3A00031, 32'hE3A00032, 32'hE3A00033, 32'hE3A00034, 32'hE3A00035, 32'hE3A00036, 32'hE3A00037,
    32'hE3A00038, 32'hE3A00039, 32'hE3A0003A, 32'hE3A0003B, 32'hE3A0003C, 32'hE3A0003D, 32'hE3A0003E, 32'hE3A0003F
  };

endpackage

// File: rtl/imem_responder_if.sv
// Fetch address interface between the fetch stage (master) and the
// instruction memory (slave).
interface imem_responder_if #(
  parameter int N = 64
) ();
  // Both channels use valid/ready: a transfer occurs on a rising edge where
  // valid && ready; valid may not drop and its payload may not change until
  // that transfer happens, while ready may change freely.
  logic         req_valid;
  logic         req_ready;
  logic [N-1:0] req_addr;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [31:0]  rsp_instr;
  logic         rsp_fault;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_instr, rsp_fault
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_instr, rsp_fault
  );
endinterface

// File: rtl/imem_rom.sv
// Combinational instruction ROM: word index in, instruction word and an
// in-range flag out. The range compare uses every index bit so nothing wraps.
module imem_rom
  import imem_pkg::*;
#(
  parameter int ROM_WORDS = 64,
  parameter int IW        = 62
) (
  input  logic [IW-1:0] i_index,
  output logic [31:0]   o_data,
  output logic          o_in_range
);

  always_comb begin
    o_in_range = (i_index < IW'(ROM_WORDS));
    o_data     = '0;
    if (o_in_range && (i_index < IW'(ROM_INIT_WORDS))) begin
      o_data = ROM_INIT[i_index[5:0]];
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts a fetch address, waits LAT states,
// then presents the ROM word (or a NOP with a fault flag) until it is taken.
module imem_responder
  import imem_pkg::*;
#(
  parameter int N         = 64,
  parameter int ROM_WORDS = 64,
  parameter int LAT       = 2
) (
  input  logic              clk,
  input  logic              reset,
  imem_responder_if.slave   bus,
  output imem_state_t       o_dbg_state
);

  localparam logic [3:0] LAT_CNT = 4'(LAT);

  imem_state_t  r_state;
  logic [3:0]   r_cnt;
  logic [N-1:0] r_addr;
  logic         r_rsp_valid;
  logic [31:0]  r_rsp_instr;
  logic         r_rsp_fault;

  logic [31:0]  w_rom_data;
  logic         w_in_range;
  logic         w_fault;
  logic         w_req_ready;

  imem_rom #(
    .ROM_WORDS (ROM_WORDS),
    .IW        (N - 2)
  ) u_rom (
    .i_index    (r_addr[N-1:2]),
    .o_data     (w_rom_data),
    .o_in_range (w_in_range)
  );

  assign w_fault     = (r_addr[1:0] != 2'b00) || !w_in_range;
  assign w_req_ready = (r_state == IDLE) || ((r_state == RESP) && bus.rsp_ready);

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_instr = r_rsp_instr;
  assign bus.rsp_fault = r_rsp_fault;
  assign o_dbg_state   = r_state;

  // WAIT always ends with the cycle that registers the ROM word, so the counter
  // starts at LAT: the response appears LAT+1 edges after acceptance for any LAT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_instr <= '0;
      r_rsp_fault <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_addr  <= bus.req_addr;
            r_cnt   <= LAT_CNT;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_rsp_valid <= 1'b1;
            r_rsp_fault <= w_fault;
            r_rsp_instr <= w_fault ? NOP_INSTR : w_rom_data;
            r_state     <= RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            if (bus.req_valid) begin
              r_addr  <= bus.req_addr;
              r_cnt   <= LAT_CNT;
              r_state <= WAIT;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: a LAT=2 and a LAT=0 instance, directed fetches,
// expected responses queued at acceptance and checked by per-instance monitors.
module tb_imem_responder;
  import imem_pkg::*;

  localparam int N = 64;
  localparam logic [31:0] NOP = 32'hD503201F;

  logic clk = 1'b0;
  logic reset = 1'b0;
  imem_state_t dbg2;
  imem_state_t dbg0;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  logic [32:0] exp2_q[$];
  logic [32:0] exp0_q[$];
  int acc2_q[$];
  int acc0_q[$];
  bit last2 = 1'b0;
  bit last0 = 1'b0;

  imem_responder_if #(.N(N)) b2 ();
  imem_responder_if #(.N(N)) b0 ();

  imem_responder #(.N(N), .ROM_WORDS(64), .LAT(2)) u_dut (
    .clk (clk), .reset (reset), .bus (b2.slave), .o_dbg_state (dbg2)
  );

  imem_responder #(.N(N), .ROM_WORDS(64), .LAT(0)) u_dut0 (
    .clk (clk), .reset (reset), .bus (b0.slave), .o_dbg_state (dbg0)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // drivers
  task automatic issue(input int d, input logic [N-1:0] addr, input logic [32:0] exp,
                       input bit keep, output int acc);
    bit ok;
    ok  = 1'b0;
    acc = -1;
    if (d == 2) begin b2.req_valid = 1'b1; b2.req_addr = addr; end
    else        begin b0.req_valid = 1'b1; b0.req_addr = addr; end
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if ((d == 2) ? b2.req_ready : b0.req_ready) begin
        @(posedge clk);
        #1;
        acc = cyc;
        ok  = 1'b1;
      end
    end
    chk("accept", ok, 1);
    if (ok) begin
      if (d == 2) begin exp2_q.push_back(exp); acc2_q.push_back(acc); end
      else        begin exp0_q.push_back(exp); acc0_q.push_back(acc); end
    end
    if (!keep) begin
      if (d == 2) b2.req_valid = 1'b0;
      else        b0.req_valid = 1'b0;
    end
  endtask

  task automatic drain(input int d);
    for (int n = 0; n < 40; n++) begin
      if (((d == 2) ? exp2_q.size() : exp0_q.size()) == 0) break;
      @(negedge clk);
    end
    chk("drain", (d == 2) ? exp2_q.size() : exp0_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int d);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      seen = (d == 2) ? b2.rsp_valid : b0.rsp_valid;
    end
    chk("rsp_valid_seen", seen, 1);
  endtask

  // scoreboard monitors: compare whenever a response is presented, pop on handshake
  always @(negedge clk) begin
    if (!reset) begin
      last2 = 1'b0;
    end else if (b2.rsp_valid) begin
      if (!last2) begin
        chk("lat2_pending", acc2_q.size() != 0, 1);
        if (acc2_q.size() != 0) chk("lat2", cyc - acc2_q.pop_front(), 3);
      end
      chk("rsp2_pending", exp2_q.size() != 0, 1);
      if (exp2_q.size() != 0) begin
        chk("rsp2", {b2.rsp_fault, b2.rsp_instr}, exp2_q[0]);
        if (b2.rsp_ready) void'(exp2_q.pop_front());
      end
      last2 = !b2.rsp_ready;
    end else begin
      last2 = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      last0 = 1'b0;
    end else if (b0.rsp_valid) begin
      if (!last0) begin
        chk("lat0_pending", acc0_q.size() != 0, 1);
        if (acc0_q.size() != 0) chk("lat0", cyc - acc0_q.pop_front(), 1);
      end
      chk("rsp0_pending", exp0_q.size() != 0, 1);
      if (exp0_q.size() != 0) begin
        chk("rsp0", {b0.rsp_fault, b0.rsp_instr}, exp0_q[0]);
        if (b0.rsp_ready) void'(exp0_q.pop_front());
      end
      last0 = !b0.rsp_ready;
    end else begin
      last0 = 1'b0;
    end
  end

  // stimulus
  initial begin
    int a1;
    int a2;
    b2.req_valid = 1'b0; b2.req_addr = '0; b2.rsp_ready = 1'b0;
    b0.req_valid = 1'b0; b0.req_addr = '0; b0.rsp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", b2.rsp_valid, 0);
    chk("rst_instr", b2.rsp_instr, 0);
    chk("rst_fault", b2.rsp_fault, 0);
    chk("rst_state", dbg2, IDLE);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready2", b2.req_ready, 1);
    chk("post_rst_ready0", b0.req_ready, 1);

    // reset while waiting: transaction dropped, block idle at once
    b2.rsp_ready = 1'b1;
    issue(2, 64'h0, {1'b0, 32'hE3A00000}, 1'b0, a1);
    @(negedge clk);
    chk("t1_in_wait", dbg2, WAIT);
    #2 reset = 1'b0;
    #1;
    chk("t1_rst_state", dbg2, IDLE);
    chk("t1_rst_valid", b2.rsp_valid, 0);
    chk("t1_rst_instr", b2.rsp_instr, 0);
    exp2_q.delete();
    acc2_q.delete();
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    chk("t1_ready_after", b2.req_ready, 1);

    // single fetch, immediate consumer
    issue(2, 64'h0, {1'b0, 32'hE3A00000}, 1'b0, a1);
    drain(2);
    chk("t2_idle", dbg2, IDLE);
    chk("t2_valid_low", b2.rsp_valid, 0);

    // stalled consumer: response held, no new request accepted
    b2.rsp_ready = 1'b0;
    issue(2, 64'h8, {1'b0, 32'hE3A00002}, 1'b0, a1);
    wait_valid(2);
    repeat (5) begin
      @(negedge clk);
      chk("t3_req_ready", b2.req_ready, 0);
      chk("t3_state", dbg2, RESP);
    end
    @(posedge clk);
    #1 b2.rsp_ready = 1'b1;
    drain(2);
    chk("t3_valid_low", b2.rsp_valid, 0);

    // reset while a response is presented
    b2.rsp_ready = 1'b0;
    issue(2, 64'h4, {1'b0, 32'hE3A00001}, 1'b0, a1);
    wait_valid(2);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t1b_rst_valid", b2.rsp_valid, 0);
    chk("t1b_rst_instr", b2.rsp_instr, 0);
    chk("t1b_rst_fault", b2.rsp_fault, 0);
    chk("t1b_rst_state", dbg2, IDLE);
    exp2_q.delete();
    acc2_q.delete();
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1 b2.rsp_ready = 1'b1;

    // back-to-back with req_valid held
    issue(2, 64'h4, {1'b0, 32'hE3A00001}, 1'b1, a1);
    issue(2, 64'hC, {1'b0, 32'hE3A00003}, 1'b0, a2);
    chk("t4_spacing", a2 - a1, 4);
    drain(2);

    // address decode boundaries
    issue(2, 64'h6, {1'b1, NOP}, 1'b0, a1);
    issue(2, 64'h100, {1'b1, NOP}, 1'b0, a1);
    issue(2, 64'hFC, {1'b0, 32'hE3A0003F}, 1'b0, a1);
    issue(2, 64'h8000_0000_0000_0000, {1'b1, NOP}, 1'b0, a1);
    issue(2, 64'h1_0000_0004, {1'b1, NOP}, 1'b0, a1);
    drain(2);

    // zero wait states; address changed after acceptance
    b0.rsp_ready = 1'b0;
    issue(0, 64'h10, {1'b0, 32'hE3A00004}, 1'b0, a1);
    b0.req_addr = 64'h14;
    wait_valid(0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 b0.rsp_ready = 1'b1;
    drain(0);
    issue(0, 64'h4, {1'b0, 32'hE3A00001}, 1'b1, a1);
    issue(0, 64'h2, {1'b1, NOP}, 1'b0, a2);
    chk("t6_spacing", a2 - a1, 2);
    drain(0);

    repeat (3) @(posedge clk);
    #1;
    chk("end_q2_empty", exp2_q.size(), 0);
    chk("end_q0_empty", exp0_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
